regfile_wb_sequencer: RTL and testbench

// Shares the register bank's single write port between two writeback requesters
// (A = ALU writeback, B = memory-load writeback). It sequences each write as a held

---
 rtl/regfile_wb_sequencer.sv | 100 ++++++++++
 tb/tb_regfile_wb_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sequencer.sv
// Arbitrates ALU (A) and load (B) writebacks onto the register bank's single write port,
// sequencing each write as a held RegWrite pulse plus one recovery cycle, and snoops reads for forwarding.
module regfile_wb_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 32,
    parameter int WR_PULSE = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic              rf_reg_write,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data
);
    localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam int LIM_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_PULSE - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);
    localparam logic [LIM_W-1:0] REG_LIM  = LIM_W'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, WRITE, RECOVER} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [AGE_W-1:0]  b_age, age_d;
    logic [ADDR_W-1:0] wreg_d, sel_reg;
    logic [DATA_W-1:0] wdata_d, sel_data;
    logic              idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            b_age        <= '0;
            rf_write_reg <= '0;
            rf_data      <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            b_age        <= age_d;
            rf_write_reg <= wreg_d;
            rf_data      <= wdata_d;
        end
    end

    always_comb begin
        idle     = (state == IDLE);
        // B overrides A only once it has lost MAX_WAIT arbitrations in a row
        a_ready  = rst_n & idle & a_valid & ~(b_valid & (b_age >= AGE_MAX));
        b_ready  = rst_n & idle & b_valid & ~a_ready;
        sel_reg  = a_ready ? a_reg  : b_reg;
        sel_data = a_ready ? a_data : b_data;
        state_d  = state;
        cnt_d    = cnt;
        age_d    = b_age;
        wreg_d   = rf_write_reg;
        wdata_d  = rf_data;
        case (state)
            IDLE: begin
                if (a_ready || b_ready) begin
                    wreg_d  = sel_reg;
                    wdata_d = sel_data;
                    // reg 0 and out-of-range selects are accepted but never written
                    if (sel_reg != '0 && {1'b0, sel_reg} < REG_LIM) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                    end
                end
                if (a_ready && b_valid && b_age != AGE_MAX) age_d = b_age + 1'b1;
                if (b_ready) age_d = '0;
            end
            WRITE: begin
                if (cnt == CNT_LAST) state_d = RECOVER;
                else                 cnt_d   = cnt + 1'b1;
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rf_reg_write = (state == WRITE);
    assign fwd1_hit     = rst_n & ~idle & (rf_write_reg == rd_reg1) & (rf_write_reg != '0);
    assign fwd2_hit     = rst_n & ~idle & (rf_write_reg == rd_reg2) & (rf_write_reg != '0);
    assign fwd_data     = rf_data;
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Scenario bench for regfile_wb_sequencer: accepted writes go to a scoreboard queue
// that a monitor drains at the start of every RegWrite pulse.
module tb_regfile_wb_sequencer;
    localparam int DATA_W = 32, ADDR_W = 6, WR_PULSE = 2;
    typedef logic [ADDR_W+DATA_W-1:0] ent_t;

    logic clk = 0, rst_n = 0;
    logic a_valid = 0, b_valid = 0, a_ready, b_ready;
    logic [ADDR_W-1:0] a_reg = '0, b_reg = '0, rf_write_reg, rd_reg1 = '0, rd_reg2 = '0;
    logic [DATA_W-1:0] a_data = '0, b_data = '0, rf_data, fwd_data;
    logic rf_reg_write, fwd1_hit, fwd2_hit;

    int checks = 0, errors = 0;
    ent_t sbq[$];
    logic prev_we = 0, rst_hit = 0;
    int plen = 0;

    regfile_wb_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .rf_write_reg(rf_write_reg), .rf_reg_write(rf_reg_write), .rf_data(rf_data),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst_n) rst_hit = 1;

    // Pulse monitor: pop on rising RegWrite, check length on falling edge
    always @(negedge clk) begin
        if (rf_reg_write && !prev_we) begin
            checks++;
            rst_hit = 0;
            plen = 1;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got reg=%0d data=%h", rf_write_reg, rf_data);
            end else begin
                ent_t e;
                e = sbq.pop_front();
                if ({rf_write_reg, rf_data} !== e) begin
                    errors++;
                    $display("FAIL write_payload got reg=%0d data=%h want reg=%0d data=%h",
                             rf_write_reg, rf_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end else if (rf_reg_write) begin
            plen++;
        end else if (prev_we && !rst_hit) begin
            checks++;
            if (plen != WR_PULSE) begin
                errors++;
                $display("FAIL pulse_len got %0d want %0d", plen, WR_PULSE);
            end
        end
        prev_we = rf_reg_write;
    end

    task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        sbq.push_back({r, d});
    endtask

    task automatic settle();
        repeat (WR_PULSE + 2) @(negedge clk);
    endtask

    task automatic wait_grant(input string nm);
        int k = 0;
        #1;
        while (!(a_ready || b_ready) && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (k >= 20) begin
            errors++;
            $display("FAIL %s timeout got no ready want a grant", nm);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; a_valid = 1; b_valid = 1; a_reg = 3; b_reg = 4;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({a_ready, b_ready, rf_reg_write, fwd1_hit, fwd2_hit} !== 5'b0 ||
            rf_write_reg !== '0 || rf_data !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b%b we=%b reg=%0d data=%h want all 0",
                     a_ready, b_ready, rf_reg_write, rf_write_reg, rf_data);
        end
        @(negedge clk);
        a_valid = 0; b_valid = 0; rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_a_only();
        a_valid = 1; a_reg = 5; a_data = 32'hDEADBEEF; #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++; $display("FAIL a_only_grant got %b%b want 10", a_ready, b_ready);
        end
        push(5, 32'hDEADBEEF);
        @(negedge clk); a_valid = 0;
        for (int t = 1; t <= 3; t++) begin
            checks++;
            if (rf_reg_write !== (t <= WR_PULSE) || rf_write_reg !== 6'd5 || rf_data !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL a_only_T%0d got we=%b reg=%0d data=%h want we=%b reg=5 data=deadbeef",
                         t, rf_reg_write, rf_write_reg, rf_data, (t <= WR_PULSE));
            end
            if (t == 3) begin
                a_valid = 1; a_reg = 6; a_data = 32'h66; #1;
                checks++;
                if (a_ready !== 1'b0) begin
                    errors++; $display("FAIL recover_ready got %b want 0", a_ready);
                end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL a_only_T4_ready got %b want 1", a_ready);
        end
        push(6, 32'h66);
        @(negedge clk); a_valid = 0;
        settle();
    endtask

    task automatic test_b_only();
        b_valid = 1; b_reg = 9; b_data = 32'hCAFEF00D; #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++; $display("FAIL b_only_grant got %b%b want 01", a_ready, b_ready);
        end
        push(9, 32'hCAFEF00D);
        @(negedge clk); b_valid = 0;
        settle();
    endtask

    task automatic test_arbitration();
        a_valid = 1; a_reg = 10; a_data = 32'hA000;
        b_valid = 1; b_reg = 11; b_data = 32'hB000;
        for (int i = 0; i < 8; i++) begin
            logic exp_b;
            exp_b = (i % 4 == 3);
            wait_grant("arb");
            checks++;
            if (b_ready !== exp_b || a_ready !== !exp_b) begin
                errors++;
                $display("FAIL arb_grant%0d got a=%b b=%b want b=%b", i, a_ready, b_ready, exp_b);
            end
            if (exp_b) push(11, b_data); else push(10, a_data);
            @(negedge clk);
            if (exp_b) b_data = b_data + 1; else a_data = a_data + 1;
        end
        a_valid = 0; b_valid = 0;
        settle();
    endtask

    task automatic test_invalid_reg();
        a_valid = 1; a_reg = 0; a_data = 32'h1111; #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL reg0_ready got %b want 1", a_ready);
        end
        @(negedge clk); a_reg = 40; a_data = 32'h2222; #1;
        checks++;
        if (a_ready !== 1'b1 || rf_reg_write !== 1'b0 || rf_write_reg !== 6'd0) begin
            errors++;
            $display("FAIL reg40_ready got rdy=%b we=%b reg=%0d want rdy=1 we=0 reg=0",
                     a_ready, rf_reg_write, rf_write_reg);
        end
        @(negedge clk); a_valid = 0; #1;
        checks++;
        if (rf_reg_write !== 1'b0 || rf_write_reg !== 6'd40 || rf_data !== 32'h2222) begin
            errors++;
            $display("FAIL reg40_latch got we=%b reg=%0d data=%h want we=0 reg=40 data=2222",
                     rf_reg_write, rf_write_reg, rf_data);
        end
        @(negedge clk);
    endtask

    task automatic test_forwarding();
        rd_reg1 = 7; rd_reg2 = 0;
        a_valid = 1; a_reg = 7; a_data = 32'h00001234; #1;
        checks++;
        if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
            errors++; $display("FAIL fwd_idle_pre got %b%b want 00", fwd1_hit, fwd2_hit);
        end
        push(7, 32'h00001234);
        @(negedge clk); a_valid = 0;
        for (int t = 1; t <= WR_PULSE + 1; t++) begin
            #1;
            checks++;
            if (fwd1_hit !== 1'b1 || fwd2_hit !== 1'b0 || fwd_data !== 32'h00001234) begin
                errors++;
                $display("FAIL fwd_T%0d got h1=%b h2=%b data=%h want h1=1 h2=0 data=00001234",
                         t, fwd1_hit, fwd2_hit, fwd_data);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
            errors++; $display("FAIL fwd_idle_post got %b%b want 00", fwd1_hit, fwd2_hit);
        end
        rd_reg1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        a_valid = 1; a_reg = 12; a_data = 32'hC000;
        b_valid = 1; b_reg = 13; b_data = 32'hD000;
        // three A wins drive B's age to the limit; the last write gets reset mid-pulse
        for (int i = 0; i < 3; i++) begin
            wait_grant("rst_pre");
            checks++;
            if (a_ready !== 1'b1) begin
                errors++; $display("FAIL rst_pre_grant%0d got a=%b want 1", i, a_ready);
            end
            push(12, a_data);
            @(negedge clk);
            if (i < 2) a_data = a_data + 1;
        end
        checks++;
        if (rf_reg_write !== 1'b1) begin
            errors++; $display("FAIL rst_T1_we got %b want 1", rf_reg_write);
        end
        rst_n = 0; a_data = 32'hE000; #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL rst_readies got %b%b want 00", a_ready, b_ready);
        end
        @(negedge clk); rst_n = 1;
        checks++;
        if (rf_reg_write !== 1'b0 || rf_write_reg !== '0 || rf_data !== '0) begin
            errors++;
            $display("FAIL rst_T2_out got we=%b reg=%0d data=%h want 0",
                     rf_reg_write, rf_write_reg, rf_data);
        end
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++; $display("FAIL rst_T2_grant got %b%b want 10 (age cleared)", a_ready, b_ready);
        end
        push(12, 32'hE000);
        @(negedge clk); a_valid = 0; b_valid = 0;
        settle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_a_only();
        test_b_only();
        test_arbitration();
        test_invalid_reg();
        test_forwarding();
        test_reset_mid_write();
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
